// File: rtl/xbox_xlr_mem_bank_if.sv
// Accelerator and host-side memory bus bundle for xbox_xlr_mem_bank.
// master = requester (accelerator core + host glue), slave = the memory bank block.
interface xbox_xlr_mem_bank_if #(
   parameter int NUM_MEMS           = 1,
   parameter int LOG2_LINES_PER_MEM = 4
);
   localparam int SEL_W = $clog2(NUM_MEMS) + 1;

   logic [NUM_MEMS-1:0][LOG2_LINES_PER_MEM-1:0] xlr_mem_addr;
   logic [NUM_MEMS-1:0][7:0][31:0]              xlr_mem_wdata;
   logic [NUM_MEMS-1:0][31:0]                   xlr_mem_be;
   logic [NUM_MEMS-1:0]                         xlr_mem_rd;
   logic [NUM_MEMS-1:0]                         xlr_mem_wr;
   logic [NUM_MEMS-1:0][7:0][31:0]              xlr_mem_rdata;

   logic [SEL_W-1:0]                            host_mem_sel;
   logic [LOG2_LINES_PER_MEM-1:0]               host_mem_addr;
   logic [2:0]                                  host_mem_word;
   logic [31:0]                                 host_mem_wdata;
   logic                                        host_mem_wr;
   logic                                        host_mem_rd;
   logic                                        host_mem_ready;
   logic [31:0]                                 host_mem_rdata;
   logic                                        host_mem_rvalid;
   logic [15:0]                                 stall_cnt;

   modport master (
      output xlr_mem_addr, xlr_mem_wdata, xlr_mem_be, xlr_mem_rd, xlr_mem_wr,
      input  xlr_mem_rdata,
      output host_mem_sel, host_mem_addr, host_mem_word, host_mem_wdata,
      output host_mem_wr, host_mem_rd,
      input  host_mem_ready, host_mem_rdata, host_mem_rvalid, stall_cnt
   );

   modport slave (
      input  xlr_mem_addr, xlr_mem_wdata, xlr_mem_be, xlr_mem_rd, xlr_mem_wr,
      output xlr_mem_rdata,
      input  host_mem_sel, host_mem_addr, host_mem_word, host_mem_wdata,
      input  host_mem_wr, host_mem_rd,
      output host_mem_ready, host_mem_rdata, host_mem_rvalid, stall_cnt
   );
endinterface

// File: rtl/xbox_xlr_mem_bank.sv
// Accelerator memory banks with a stalling 32-bit host word port.
// Optional macro XLR_MEM_WR_BYPASS_EN: write-first result on same-bank rd+wr (default read-first).
module xbox_xlr_mem_bank #(
   parameter int NUM_MEMS           = 1,
   parameter int LOG2_LINES_PER_MEM = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   xbox_xlr_mem_bank_if.slave  bus
);
   localparam int LINES = 1 << LOG2_LINES_PER_MEM;
   localparam int SEL_W = $clog2(NUM_MEMS) + 1;

`ifdef XLR_MEM_WR_BYPASS_EN
   localparam bit WR_BYPASS = 1'b1;
`else
   localparam bit WR_BYPASS = 1'b0;
`endif

   typedef logic [7:0][31:0] line_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_STALL,
      ST_ACCEPT,
      ST_RESP
   } host_state_t;

   line_t                   mem [NUM_MEMS][LINES];
   line_t                   rd_line [NUM_MEMS];
   line_t                   merged  [NUM_MEMS];
   logic [NUM_MEMS-1:0][7:0][31:0] xlr_rdata_q;

   host_state_t             state_q, state_d;
   logic [15:0]             stall_cnt_q;
   logic [31:0]             host_rdata_q;
   logic                    conflict;
   logic                    sel_ok;
   logic [31:0]             host_word;
   logic                    host_req;
   logic                    ready;
   logic                    stall_inc;
   logic                    host_wr_fire;
   logic                    host_rd_fire;

   // Per-bank addressed line and the line after the byte-enabled merge.
   always_comb begin
      for (int b = 0; b < NUM_MEMS; b++) begin
         rd_line[b] = mem[b][bus.xlr_mem_addr[b]];
         merged[b]  = rd_line[b];
         for (int w = 0; w < 8; w++) begin
            for (int y = 0; y < 4; y++) begin
               if (bus.xlr_mem_be[b][w*4+y]) begin
                  merged[b][w][8*y +: 8] = bus.xlr_mem_wdata[b][w][8*y +: 8];
               end
            end
         end
      end
   end

   // NOTE: every variable gets a default before any branch so no latch is inferred.
   always_comb begin
      conflict  = 1'b0;
      sel_ok    = 1'b0;
      host_word = 32'h0;
      for (int b = 0; b < NUM_MEMS; b++) begin
         if (bus.host_mem_sel == SEL_W'(b)) begin
            sel_ok    = 1'b1;
            conflict  = bus.xlr_mem_rd[b] | bus.xlr_mem_wr[b];
            host_word = mem[b][bus.host_mem_addr][bus.host_mem_word];
         end
      end
   end

   assign host_req = bus.host_mem_rd | bus.host_mem_wr;

   // The accelerator always wins: any cycle it touches the host's bank, the host waits,
   // including the very first request cycle and a late hit while in ACCEPT.
   always_comb begin
      state_d      = state_q;
      ready        = 1'b0;
      stall_inc    = 1'b0;
      host_wr_fire = 1'b0;
      host_rd_fire = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (host_req) begin
               if (conflict) begin
                  state_d   = ST_STALL;
                  stall_inc = 1'b1;
               end else begin
                  state_d = ST_ACCEPT;
               end
            end
         end
         ST_STALL: begin
            if (conflict) stall_inc = 1'b1;
            else          state_d   = ST_ACCEPT;
         end
         ST_ACCEPT: begin
            if (conflict) begin
               state_d   = ST_STALL;
               stall_inc = 1'b1;
            end else begin
               ready = 1'b1;
               if (bus.host_mem_wr) begin
                  host_wr_fire = 1'b1;
                  state_d      = ST_IDLE;
               end else if (bus.host_mem_rd) begin
                  host_rd_fire = 1'b1;
                  state_d      = ST_RESP;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         stall_cnt_q  <= 16'h0;
         host_rdata_q <= 32'h0;
      end else begin
         state_q <= state_d;
         if (stall_inc && stall_cnt_q != 16'hFFFF) stall_cnt_q <= stall_cnt_q + 16'h1;
         if (host_rd_fire) host_rdata_q <= sel_ok ? host_word : 32'hDEAD_BEEF;
      end
   end

   // NOTE: the storage is reset because software relies on lines reading back as zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         xlr_rdata_q <= '0;
         for (int b = 0; b < NUM_MEMS; b++) begin
            for (int l = 0; l < LINES; l++) mem[b][l] <= '0;
         end
      end else begin
         for (int b = 0; b < NUM_MEMS; b++) begin
            if (bus.xlr_mem_wr[b]) mem[b][bus.xlr_mem_addr[b]] <= merged[b];
            if (bus.xlr_mem_rd[b]) begin
               xlr_rdata_q[b] <= (WR_BYPASS && bus.xlr_mem_wr[b]) ? merged[b] : rd_line[b];
            end
         end
         // Host writes only fire when the accelerator is off this bank, so they never collide.
         if (host_wr_fire) begin
            for (int b = 0; b < NUM_MEMS; b++) begin
               if (bus.host_mem_sel == SEL_W'(b)) begin
                  mem[b][bus.host_mem_addr][bus.host_mem_word] <= bus.host_mem_wdata;
               end
            end
         end
      end
   end

   assign bus.xlr_mem_rdata   = xlr_rdata_q;
   assign bus.host_mem_ready  = ready;
   assign bus.host_mem_rdata  = host_rdata_q;
   assign bus.host_mem_rvalid = (state_q == ST_RESP);
   assign bus.stall_cnt       = stall_cnt_q;

endmodule

// File: tb/tb_xbox_xlr_mem_bank.sv
// Self-checking bench for xbox_xlr_mem_bank: reference line model plus an expected-result queue.
module tb_xbox_xlr_mem_bank;
   localparam int NM = 1;
   localparam int LG = 4;

   typedef logic [7:0][31:0] line_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   xbox_xlr_mem_bank_if #(.NUM_MEMS(NM), .LOG2_LINES_PER_MEM(LG)) bus ();

   xbox_xlr_mem_bank #(.NUM_MEMS(NM), .LOG2_LINES_PER_MEM(LG)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int           n_vec = 0;
   int           n_err = 0;
   line_t        model [16];
   logic [255:0] exp_q [$];
   string        tag_q [$];

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic accel_idle();
      bus.xlr_mem_rd    = '0;
      bus.xlr_mem_wr    = '0;
      bus.xlr_mem_be    = '0;
      bus.xlr_mem_wdata = '0;
      bus.xlr_mem_addr  = '0;
   endtask

   task automatic host_idle();
      bus.host_mem_rd    = 1'b0;
      bus.host_mem_wr    = 1'b0;
      bus.host_mem_sel   = '0;
      bus.host_mem_addr  = '0;
      bus.host_mem_word  = '0;
      bus.host_mem_wdata = '0;
   endtask

   // One accelerator cycle on bank 0; a read's result is queued then compared a cycle later.
   task automatic accel(input logic [3:0] a, input line_t wd, input logic [31:0] be,
                        input bit rd, input bit wr, input string tag);
      line_t m;
      m = model[a];
      for (int w = 0; w < 8; w++)
         for (int y = 0; y < 4; y++)
            if (be[w*4+y]) m[w][8*y +: 8] = wd[w][8*y +: 8];
      bus.xlr_mem_addr[0]  = a;
      bus.xlr_mem_wdata[0] = wd;
      bus.xlr_mem_be[0]    = be;
      bus.xlr_mem_rd[0]    = rd;
      bus.xlr_mem_wr[0]    = wr;
      if (rd) begin
`ifdef XLR_MEM_WR_BYPASS_EN
         exp_q.push_back(wr ? m : model[a]);
`else
         exp_q.push_back(model[a]);
`endif
         tag_q.push_back(tag);
      end
      if (wr) model[a] = m;
      tick();
      accel_idle();
      if (rd) check(tag_q.pop_front(), bus.xlr_mem_rdata[0], exp_q.pop_front());
   endtask

   // Host request held until ready; reads are compared when rvalid arrives.
   task automatic host(input logic [1:0] sel, input logic [3:0] a, input logic [2:0] word,
                       input logic [31:0] wd, input bit wr, input bit rd,
                       input string tag, output int lat);
      int cyc;
      bus.host_mem_sel   = sel[0];
      bus.host_mem_addr  = a;
      bus.host_mem_word  = word;
      bus.host_mem_wdata = wd;
      bus.host_mem_wr    = wr;
      bus.host_mem_rd    = rd;
      if (rd && !wr) begin
         exp_q.push_back((sel >= NM) ? 256'h0DEAD_BEEF : 256'(model[a][word]));
         tag_q.push_back(tag);
      end
      if (wr && sel < NM) model[a][word] = wd;
      cyc = 0;
      while (!bus.host_mem_ready && cyc < 20) begin
         tick();
         cyc++;
      end
      check({tag, "_accept"}, bus.host_mem_ready, 1);
      tick();
      cyc++;
      host_idle();
      if (rd && !wr) begin
         while (!bus.host_mem_rvalid && cyc < 40) begin
            tick();
            cyc++;
         end
         check({tag, "_rvalid"}, bus.host_mem_rvalid, 1);
         check(tag_q.pop_front(), bus.host_mem_rdata, exp_q.pop_front());
      end else begin
         check({tag, "_no_rvalid"}, bus.host_mem_rvalid, 0);
      end
      lat = cyc;
   endtask

   initial begin
      #300000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      line_t wd;
      line_t keep;
      int    lat;

      accel_idle();
      host_idle();
      for (int l = 0; l < 16; l++) model[l] = '0;
      #1;
      check("rst_xlr_rdata", bus.xlr_mem_rdata, 0);
      check("rst_rvalid", bus.host_mem_rvalid, 0);
      check("rst_stall_cnt", bus.stall_cnt, 0);
      check("rst_host_rdata", bus.host_mem_rdata, 0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      tick();

      for (int w = 0; w < 8; w++) wd[w] = 32'(w + 1);
      accel(4'd1, wd, 32'hFFFF_FFFF, 1'b0, 1'b1, "wr_line1");
      accel(4'd1, '0, '0, 1'b1, 1'b0, "rd_line1");
      keep = bus.xlr_mem_rdata[0];
      tick();
      check("rdata_hold", bus.xlr_mem_rdata[0], keep);

      wd = {8{32'hAAAA_AAAA}};
      accel(4'd2, wd, 32'hFFFF_FFFF, 1'b0, 1'b1, "wr_line2");
      wd = '0;
      wd[0] = 32'h1122_3344;
      accel(4'd2, wd, 32'h0000_000F, 1'b0, 1'b1, "wr_line2_be");
      accel(4'd2, '0, '0, 1'b1, 1'b0, "rd_line2");

      accel(4'd3, '0, 32'hFFFF_FFFF, 1'b0, 1'b1, "clr_line3");
      wd = '0;
      wd[0] = 32'd5;
      accel(4'd3, wd, 32'hFFFF_FFFF, 1'b1, 1'b1, "rdwr_line3");
      accel(4'd3, '0, '0, 1'b1, 1'b0, "rd_line3");

      accel(4'd1, {8{32'hFFFF_FFFF}}, 32'h0, 1'b0, 1'b1, "wr_be0");
      accel(4'd1, '0, '0, 1'b1, 1'b0, "rd_line1_be0");

      for (int i = 0; i < 6; i++) begin
         logic [3:0] a;
         a = 4'($urandom_range(4, 15));
         for (int w = 0; w < 8; w++) wd[w] = $urandom;
         accel(a, wd, $urandom, 1'b0, 1'b1, $sformatf("rnd_wr%0d", i));
         accel(a, '0, '0, 1'b1, 1'b0, $sformatf("rnd_rd%0d", i));
      end

      // Host write to bank 0 while the accelerator reads bank 0 for three cycles.
      bus.host_mem_sel   = '0;
      bus.host_mem_addr  = 4'd0;
      bus.host_mem_word  = 3'd2;
      bus.host_mem_wdata = 32'h7;
      bus.host_mem_wr    = 1'b1;
      bus.xlr_mem_addr[0] = 4'd0;
      bus.xlr_mem_rd[0]   = 1'b1;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("stall_ready%0d", i), bus.host_mem_ready, 0);
         tick();
      end
      accel_idle();
      model[0][2] = 32'h7;
      lat = 0;
      while (!bus.host_mem_ready && lat < 10) begin
         tick();
         lat++;
      end
      check("stall_accept", bus.host_mem_ready, 1);
      check("stall_cnt", bus.stall_cnt, 3);
      tick();
      host_idle();

      host(2'd0, 4'd0, 3'd2, 32'h0, 1'b0, 1'b1, "host_rd_w2", lat);
      check("host_rd_latency", lat, 2);
      host(2'd1, 4'd0, 3'd0, 32'h0, 1'b0, 1'b1, "host_rd_badsel", lat);
      host(2'd1, 4'd0, 3'd0, 32'h1234_5678, 1'b1, 1'b0, "host_wr_badsel", lat);
      host(2'd0, 4'd6, 3'd5, 32'hCAFE_0001, 1'b1, 1'b1, "host_rdwr", lat);
      host(2'd0, 4'd6, 3'd5, 32'h0, 1'b0, 1'b1, "host_rd_rdwr", lat);
      host(2'd0, 4'd1, 3'd5, 32'h0, 1'b0, 1'b1, "host_rd_accel_line", lat);
      accel(4'd0, '0, '0, 1'b1, 1'b0, "rd_line0_hostwr");
      check("stall_cnt_final", bus.stall_cnt, 3);

      // Reset while the host sits in STALL.
      bus.host_mem_sel    = '0;
      bus.host_mem_addr   = 4'd5;
      bus.host_mem_word   = 3'd0;
      bus.host_mem_wdata  = 32'h55;
      bus.host_mem_wr     = 1'b1;
      bus.xlr_mem_addr[0] = 4'd0;
      bus.xlr_mem_rd[0]   = 1'b1;
      repeat (2) tick();
      rst_n = 1'b0;
      #1;
      check("midrst_stall_cnt", bus.stall_cnt, 0);
      check("midrst_rvalid", bus.host_mem_rvalid, 0);
      check("midrst_xlr_rdata", bus.xlr_mem_rdata, 0);
      accel_idle();
      host_idle();
      for (int l = 0; l < 16; l++) model[l] = '0;
      @(negedge clk) rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("post_rst_rvalid%0d", i), bus.host_mem_rvalid, 0);
      end
      for (int l = 0; l < 16; l++) accel(4'(l), '0, '0, 1'b1, 1'b0, $sformatf("post_rst_line%0d", l));
      host(2'd0, 4'd5, 3'd0, 32'h0, 1'b0, 1'b1, "post_rst_host_rd", lat);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
